// File: rtl/wr_req_arbiter.sv
//==============================================================================
// Module   : wr_req_arbiter
// Brief    : Slave-side round-robin write-request arbiter; optional slave-ack
//            timeout enabled by defining WR_REQ_TIMEOUT_EN.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module wr_req_arbiter #(
    parameter int         AWIDTH         = 32,
    parameter int         DWIDTH         = 32,
    parameter int         NUM_MASTERS    = 2,
    parameter logic [0:0] SLAVE_ID       = 1'b0,
    parameter int         TIMEOUT_CYCLES = 64
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NUM_MASTERS-1:0]          m_req,
    input  logic [NUM_MASTERS-1:0]          m_sel,
    input  logic [NUM_MASTERS*AWIDTH-1:0]   m_addr,
    input  logic [NUM_MASTERS*DWIDTH-1:0]   m_wdata,
    output logic [NUM_MASTERS-1:0]          m_ack,
    output logic                            s_req,
    output logic [AWIDTH-1:0]               s_addr,
    output logic [DWIDTH-1:0]               s_wdata,
    input  logic                            s_ack,
    output logic [$clog2(NUM_MASTERS)-1:0]  grant_id,
    output logic                            busy
`ifdef WR_REQ_TIMEOUT_EN
    ,
    output logic                            timeout_err
`endif
);

    localparam int c_IDW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {
        ST_ARB     = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [c_IDW-1:0]         r_ptr, w_ptr_nxt;
    logic [c_IDW-1:0]         r_gid, w_gid_nxt;
    logic [AWIDTH-1:0]        r_addr, w_addr_nxt;
    logic [DWIDTH-1:0]        r_wdata, w_wdata_nxt;
    logic                     r_sreq, w_sreq_nxt;
    logic [NUM_MASTERS-1:0]   r_mack, w_mack_nxt;
    logic [NUM_MASTERS-1:0]   w_valid;
    logic                     w_found;
    logic [c_IDW-1:0]         w_win;

`ifdef WR_REQ_TIMEOUT_EN
    localparam int               c_CW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CW-1:0]  c_CNT_LAST = c_CW'(TIMEOUT_CYCLES - 1);
    logic [c_CW-1:0]             r_cnt, w_cnt_nxt;
    logic                        r_terr, w_terr_nxt;
`endif

    function automatic logic [c_IDW-1:0] f_wrap(input logic [c_IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_MASTERS) s = s - NUM_MASTERS;
        return c_IDW'(s);
    endfunction

    assign w_valid = m_req & ~(m_sel ^ {NUM_MASTERS{SLAVE_ID}});

    // Scan from the farthest offset down so the master nearest the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (w_valid[f_wrap(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = f_wrap(r_ptr, k);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gid_nxt   = r_gid;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_sreq_nxt  = r_sreq;
        w_mack_nxt  = '0;
`ifdef WR_REQ_TIMEOUT_EN
        w_cnt_nxt   = r_cnt;
        w_terr_nxt  = r_terr;
`endif
        case (r_state)
            ST_ARB: begin
                if (w_found) begin
                    w_gid_nxt   = w_win;
                    w_addr_nxt  = m_addr[w_win*AWIDTH +: AWIDTH];
                    w_wdata_nxt = m_wdata[w_win*DWIDTH +: DWIDTH];
                    w_sreq_nxt  = 1'b1;
                    w_state_nxt = ST_ISSUE;
`ifdef WR_REQ_TIMEOUT_EN
                    w_cnt_nxt   = '0;
`endif
                end
            end
            ST_ISSUE: begin
                if (s_ack) begin
                    w_sreq_nxt  = 1'b0;
                    w_mack_nxt  = NUM_MASTERS'(1) << r_gid;
                    w_state_nxt = ST_RELEASE;
                end
`ifdef WR_REQ_TIMEOUT_EN
                else if (r_cnt == c_CNT_LAST) begin
                    w_sreq_nxt  = 1'b0;
                    w_mack_nxt  = NUM_MASTERS'(1) << r_gid;
                    w_terr_nxt  = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
`endif
            end
            ST_RELEASE: begin
                // Wait for the granted master to drop its held request level.
                if (!m_req[r_gid]) begin
                    w_ptr_nxt   = (r_gid == c_IDW'(NUM_MASTERS - 1)) ? '0 : r_gid + 1'b1;
                    w_state_nxt = ST_ARB;
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= ST_ARB;
            r_ptr   <= '0;
            r_gid   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_sreq  <= 1'b0;
            r_mack  <= '0;
`ifdef WR_REQ_TIMEOUT_EN
            r_cnt   <= '0;
            r_terr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gid   <= w_gid_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_sreq  <= w_sreq_nxt;
            r_mack  <= w_mack_nxt;
`ifdef WR_REQ_TIMEOUT_EN
            r_cnt   <= w_cnt_nxt;
            r_terr  <= w_terr_nxt;
`endif
        end
    end

    assign m_ack    = r_mack;
    assign s_req    = r_sreq;
    assign s_addr   = r_addr;
    assign s_wdata  = r_wdata;
    assign grant_id = r_gid;
    assign busy     = (r_state != ST_ARB);
`ifdef WR_REQ_TIMEOUT_EN
    assign timeout_err = r_terr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wr_req_arbiter.sv
//==============================================================================
// Module   : tb_wr_req_arbiter
// Brief    : Self-checking bench for wr_req_arbiter with a transaction-level model.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_wr_req_arbiter;

    localparam int         AW  = 32;
    localparam int         DW  = 32;
    localparam int         N   = 2;
    localparam int         TO  = 8;
    localparam logic [0:0] SID = 1'b0;

    logic                   aclk = 1'b0;
    logic                   aresetn;
    logic [N-1:0]           m_req;
    logic [N-1:0]           m_sel;
    logic [N*AW-1:0]        m_addr;
    logic [N*DW-1:0]        m_wdata;
    logic [N-1:0]           m_ack;
    logic                   s_req;
    logic [AW-1:0]          s_addr;
    logic [DW-1:0]          s_wdata;
    logic                   s_ack;
    logic [$clog2(N)-1:0]   grant_id;
    logic                   busy;
`ifdef WR_REQ_TIMEOUT_EN
    logic                   timeout_err;
`endif

    wr_req_arbiter #(
        .AWIDTH(AW), .DWIDTH(DW), .NUM_MASTERS(N), .SLAVE_ID(SID), .TIMEOUT_CYCLES(TO)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_req(m_req), .m_sel(m_sel), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .grant_id(grant_id), .busy(busy)
`ifdef WR_REQ_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;
    logic checking = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: one outstanding write, released when the winner drops req.
    logic           mdl_active, mdl_acked, mdl_sreq, mdl_terr;
    int             mdl_gid, mdl_ptr, mdl_cnt;
    logic [AW-1:0]  mdl_addr;
    logic [DW-1:0]  mdl_wdata;
    logic [N-1:0]   mdl_ack;

    always @(posedge aclk) begin
        int i;
        if (!aresetn) begin
            mdl_active = 0; mdl_acked = 0; mdl_sreq = 0; mdl_terr = 0;
            mdl_gid = 0; mdl_ptr = 0; mdl_cnt = 0;
            mdl_addr = '0; mdl_wdata = '0; mdl_ack = '0;
        end else begin
            mdl_ack = '0;
            if (!mdl_active) begin
                for (int k = 0; k < N; k++) begin
                    i = (mdl_ptr + k) % N;
                    if (!mdl_active && m_req[i] && (m_sel[i] == SID)) begin
                        mdl_active = 1; mdl_gid = i; mdl_sreq = 1; mdl_cnt = 0;
                        mdl_addr  = m_addr[i*AW +: AW];
                        mdl_wdata = m_wdata[i*DW +: DW];
                    end
                end
            end else if (!mdl_acked) begin
                mdl_cnt++;
                if (s_ack) begin
                    mdl_sreq = 0; mdl_acked = 1; mdl_ack[mdl_gid] = 1'b1;
                end
`ifdef WR_REQ_TIMEOUT_EN
                else if (mdl_cnt == TO) begin
                    mdl_sreq = 0; mdl_acked = 1; mdl_ack[mdl_gid] = 1'b1; mdl_terr = 1;
                end
`endif
            end else if (!m_req[mdl_gid]) begin
                mdl_active = 0; mdl_acked = 0; mdl_ptr = (mdl_gid + 1) % N;
            end
        end
    end

    always @(negedge aclk) begin
        if (checking) begin
            chk("s_req",    64'(s_req),    64'(mdl_sreq));
            chk("m_ack",    64'(m_ack),    64'(mdl_ack));
            chk("busy",     64'(busy),     64'(mdl_active));
            chk("grant_id", 64'(grant_id), 64'(mdl_gid));
            chk("s_addr",   64'(s_addr),   64'(mdl_addr));
            chk("s_wdata",  64'(s_wdata),  64'(mdl_wdata));
`ifdef WR_REQ_TIMEOUT_EN
            chk("timeout_err", 64'(timeout_err), 64'(mdl_terr));
`endif
        end
    end

    int glog[$];
    always @(negedge aclk) begin
        for (int i = 0; i < N; i++) if (m_ack[i] === 1'b1) glog.push_back(i);
    end

    // Master agents: hold req until ack, keep it one more cycle, drop for one cycle.
    int   tot[N];
    int   done[N];
    logic ph[N];
    initial begin
        m_req = '0;
        for (int i = 0; i < N; i++) begin done[i] = 0; ph[i] = 0; end
        forever begin
            @(negedge aclk);
            for (int i = 0; i < N; i++) begin
                if (ph[i]) begin
                    m_req[i] = 1'b0; ph[i] = 1'b0;
                end else if (m_ack[i] === 1'b1) begin
                    done[i]++; ph[i] = 1'b1;
                end else begin
                    m_req[i] = (done[i] < tot[i]);
                end
            end
        end
    end

    logic slv_en;
    int   slv_lat;
    int   stray_req;
    int   stray_done;
    initial begin
        int scnt;
        s_ack = 0; scnt = 0; stray_done = 0;
        forever begin
            @(negedge aclk);
            if (s_ack) begin
                s_ack = 0; scnt = 0;
            end else if (stray_req != stray_done) begin
                s_ack = 1; stray_done++;
            end else if (slv_en && s_req) begin
                scnt++;
                if (scnt >= slv_lat) s_ack = 1;
            end else begin
                scnt = 0;
            end
        end
    end

    task automatic step();
        @(negedge aclk);
        #1;
    endtask

    task automatic wait_sreq(input string nm);
        int k;
        k = 0;
        while (s_req !== 1'b1 && k < 100) begin step(); k++; end
        chk(nm, 64'(s_req), 64'd1);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((busy !== 1'b0 || m_req !== '0) && k < 100) begin step(); k++; end
        chk(nm, 64'(busy), 64'd0);
    endtask

    task automatic wait_grants(input int n, input string nm);
        int k;
        k = 0;
        while (glog.size() < n && k < 400) begin step(); k++; end
        chk(nm, 64'(glog.size()), 64'(n));
    endtask

    initial begin
        int k, pulses, d;
        int exp8[8];
        exp8 = '{1, 0, 1, 0, 1, 0, 1, 0};
        aresetn = 0; m_sel = '0; m_addr = '0; m_wdata = '0;
        for (int i = 0; i < N; i++) tot[i] = 0;
        slv_en = 1; slv_lat = 3; stray_req = 0;
        repeat (3) step();
        checking = 1;
        chk("rst s_req", 64'(s_req), 0);
        chk("rst m_ack", 64'(m_ack), 0);
        chk("rst busy", 64'(busy), 0);
        chk("rst grant_id", 64'(grant_id), 0);
        chk("rst s_addr", 64'(s_addr), 0);
        chk("rst s_wdata", 64'(s_wdata), 0);
        aresetn = 1;

        // Single write from m0
        m_addr[0 +: AW] = 32'h0000_0010; m_wdata[0 +: DW] = 32'hDEADBEEF;
        tot[0] = 1;
        wait_sreq("single s_req rise");
        chk("single s_addr", 64'(s_addr), 64'h10);
        chk("single s_wdata", 64'(s_wdata), 64'hDEADBEEF);
        m_addr[0 +: AW] = 32'h0000_0099; m_wdata[0 +: DW] = 32'h1234_5678;
        k = 0;
        while (m_ack[0] !== 1'b1 && k < 20) begin step(); k++; end
        chk("single ack latency", 64'(k), 3);
        chk("single s_addr held", 64'(s_addr), 64'h10);
        pulses = 0;
        for (int j = 0; j < 4; j++) begin
            if (m_ack[0] === 1'b1) pulses++;
            step();
        end
        chk("single ack pulses", 64'(pulses), 1);
        wait_idle("single busy clear");
        chk("single s_wdata kept", 64'(s_wdata), 64'hDEADBEEF);

        // Sel filter plus a stray s_ack while idle
        m_sel[1] = 1'b1; tot[1] = 1; stray_req++;
        pulses = 0;
        for (int j = 0; j < 20; j++) begin
            step();
            if (s_req !== 1'b0 || m_ack !== '0) pulses++;
        end
        chk("sel filter activity", 64'(pulses), 0);
        tot[1] = done[1]; m_sel[1] = 1'b0;
        wait_idle("sel filter idle");

        // Simultaneous requests with pointer at 0
        aresetn = 0; step(); aresetn = 1;
        glog.delete();
        m_addr[0 +: AW] = 32'hA000_0000; m_wdata[0 +: DW] = 32'h0000_00A0;
        m_addr[AW +: AW] = 32'hB000_0000; m_wdata[DW +: DW] = 32'h0000_00B1;
        tot[0] = done[0] + 2; tot[1] = done[1] + 1;
        wait_grants(3, "simul grant count");
        if (glog.size() >= 3) begin
            chk("simul grant0", 64'(glog[0]), 0);
            chk("simul grant1", 64'(glog[1]), 1);
            chk("simul grant2", 64'(glog[2]), 0);
        end
        wait_idle("simul idle");
        chk("simul last s_addr", 64'(s_addr), 64'hA000_0000);

        // Starvation: both keep re-requesting
        glog.delete();
        tot[0] = done[0] + 4; tot[1] = done[1] + 4;
        wait_grants(8, "starve grant count");
        if (glog.size() >= 8)
            for (int j = 0; j < 8; j++) chk($sformatf("starve grant%0d", j), 64'(glog[j]), 64'(exp8[j]));
        wait_idle("starve idle");

        // Reset mid-ISSUE on an m1 grant
        slv_en = 0;
        tot[1] = done[1] + 1;
        wait_sreq("rstmid s_req rise");
        step(); step();
        chk("rstmid grant before", 64'(grant_id), 1);
        d = done[1];
        aresetn = 0; step();
        chk("rstmid s_req", 64'(s_req), 0);
        chk("rstmid m_ack", 64'(m_ack), 0);
        chk("rstmid grant_id", 64'(grant_id), 0);
        chk("rstmid busy", 64'(busy), 0);
        aresetn = 1; slv_en = 1;
        glog.delete();
        wait_grants(1, "rstmid regrant");
        if (glog.size() >= 1) chk("rstmid regrant id", 64'(glog[0]), 1);
        chk("rstmid one completion", 64'(done[1]), 64'(d + 1));
        wait_idle("rstmid idle");

`ifdef WR_REQ_TIMEOUT_EN
        slv_en = 0;
        tot[0] = done[0] + 1;
        wait_sreq("timeout s_req rise");
        k = 0;
        while (m_ack[0] !== 1'b1 && k < 40) begin step(); k++; end
        chk("timeout ack latency", 64'(k), 64'(TO));
        chk("timeout err set", 64'(timeout_err), 1);
        chk("timeout s_req low", 64'(s_req), 0);
        repeat (5) step();
        chk("timeout err sticky", 64'(timeout_err), 1);
        slv_en = 1;
        wait_idle("timeout idle");
`endif

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish within 1 ms");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/wr_req_arbiter.md
Name: wr_req_arbiter

Overview:
- Slave-side end of the crossbar write-request path.
- Each master port drives a write request bundle: req, sel, addr, wdata. The request is held until that master sees a one-cycle ack.
- This block collects requests from all masters whose sel matches SLAVE_ID and arbitrates them round-robin. It forwards the winner to the slave port with a req/ack handshake, then returns the ack to the granted master.
- One instance sits in front of each slave.

Parameters:
- AWIDTH, 32, address width.
- DWIDTH, 32, write data width.
- NUM_MASTERS, 2, number of master ports (2..8).
- SLAVE_ID, 0, sel value (1 bit) routed to this slave.
- TIMEOUT_CYCLES, 64, slave-ack timeout. Used only with the optional feature.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  synchronous active-low reset.
- m_req  in  NUM_MASTERS  per-master write request level.
- m_sel  in  NUM_MASTERS  per-master target slave select.
- m_addr  in  NUM_MASTERS*AWIDTH  per-master address; master i occupies bits [i*AWIDTH +: AWIDTH].
- m_wdata  in  NUM_MASTERS*DWIDTH  per-master write data, same packing.
- m_ack  out  NUM_MASTERS  one-hot, one-cycle ack to the granted master.
- s_req  out  1  write request to slave.
- s_addr  out  AWIDTH  latched address.
- s_wdata  out  DWIDTH  latched write data.
- s_ack  in  1  slave completion.
- grant_id  out  $clog2(NUM_MASTERS)  index of the current or last granted master.
- busy  out  1  high in any state other than ARB.

Behaviour:
- Reset (aresetn=0 sampled at posedge aclk):
  - m_ack=0, s_req=0, s_addr=0, s_wdata=0, grant_id=0, busy=0.
  - Round-robin pointer = 0; state = ARB.
  - Reset mid-transaction abandons it silently: no ack is issued.
- Eligibility: valid[i] = m_req[i] & (m_sel[i]==SLAVE_ID). Requests whose sel does not match are ignored entirely.
- Arbitration: search starts at the pointer and wraps upward modulo NUM_MASTERS; the first valid[i] wins.
- State ARB:
  - If any valid: latch grant_id=i, s_addr=m_addr[i], s_wdata=m_wdata[i]; set s_req=1; go to ISSUE.
  - Latency: valid seen at edge N gives s_req=1 visible after edge N.
- State ISSUE:
  - s_req, s_addr and s_wdata are held stable.
  - On s_ack=1: s_req=0, m_ack[grant_id]=1, go to RELEASE.
  - Master inputs are not re-sampled during ISSUE; changes to m_addr or m_wdata are ignored.
- State RELEASE:
  - m_ack is cleared after exactly one cycle.
  - Stay until m_req[grant_id]=0. Then pointer = grant_id+1 (wrapping to 0), busy=0, go to ARB.
  - This prevents a second grant on the level still held by the master, which drops req one cycle after seeing ack.
- Fairness and simultaneous events:
  - Two masters requesting in the same cycle: the one at or after the pointer wins; the other is granted next.
  - A master that re-asserts immediately after release cannot win twice while another valid master waits.
  - s_ack in ARB or RELEASE is ignored.
  - s_ack arriving in the same cycle s_req rises is not possible; s_ack is sampled only in ISSUE.
- s_addr and s_wdata keep their last value after completion. Only reset clears them.
- m_ack is never multi-hot.

Optional Feature:
- Macro WR_REQ_TIMEOUT_EN.
- When defined:
  - A counter runs in ISSUE.
  - If s_ack has not arrived after TIMEOUT_CYCLES cycles: drop s_req, pulse m_ack[grant_id] anyway, and set sticky output timeout_err (1 bit, added port, reset 0, cleared by reset only). Then go to RELEASE as normal.
  - The counter resets on entry to ISSUE.
- When undefined: no counter and no timeout_err port; ISSUE waits for s_ack indefinitely.

Test Plan:
- Single write: SLAVE_ID=0; m0 req=1, sel=0, addr=0x0000_0010, wdata=0xDEADBEEF.
  - Expect s_req=1 the next cycle with s_addr=0x10, s_wdata=0xDEADBEEF.
  - s_ack held 1 for one cycle at cycle +3 → m_ack[0] pulses for exactly 1 cycle.
  - After m0 drops req, busy returns to 0.
- Sel filter: m1 req=1, sel=1 into the SLAVE_ID=0 instance → s_req stays 0 and m_ack stays 0 for 20 cycles.
- Simultaneous requests: m0 and m1 request together with pointer=0 → m0 served first (grant_id=0), then m1 (grant_id=1) without m1 deasserting req. A third request from m0 is served only after m1.
- Starvation check: m0 re-requests every cycle after release while m1 holds req → grants alternate 0,1,0,1 over 8 transactions.
- Reset mid-ISSUE: aresetn=0 for 1 cycle while s_req=1 → next cycle s_req=0, m_ack=0, grant_id=0, state ARB. A pending request is then re-granted normally.
- WR_REQ_TIMEOUT_EN with TIMEOUT_CYCLES=8, s_ack never driven:
  - m_ack[0] pulses 8 cycles after s_req rises.
  - timeout_err=1 and stays 1; s_req=0.
